// File: rtl/serial_in_receiver.sv
// ============================================================================
// serial_in_receiver
//
// Collects a 4-bit word from a serial line, one bit per ENB strobe, and
// presents it on WORD with a valid/acknowledge handshake. A frame is opened
// by START while idle in serial mode (MODO = 2'b00); any other MODO value
// aborts a frame in flight. Bits may enter from either end (DIR per bit).
//
// Optional feature (macro PARITY_CHK_EN): each frame carries a fifth bit,
// a parity bit checked against PARITY_ODD. A failing frame is dropped and
// the sticky PAR_ERR flag is set. Without the macro, frames are 4 bits and
// PAR_ERR is constant 0.
//
// Parameters
//   INIT_WORD  - value of WORD during and after reset
//   PARITY_ODD - 0 = even parity, 1 = odd parity (PARITY_CHK_EN builds only)
//
// Ports
//   CLK        in   single clock, rising edge
//   RESET      in   synchronous, active-high reset
//   ENB        in   bit strobe; S_IN is sampled only when ENB = 1
//   MODO[1:0]  in   2'b00 = serial shift mode, anything else = not shifting
//   DIR        in   0 = shift left (bit enters bit 0), 1 = right (enters bit 3)
//   S_IN       in   serial data
//   START      in   frame start request (honoured only in IDLE with MODO = 00)
//   WORD_ACK   in   consumer accepts WORD
//   WORD[3:0]  out  last completed word
//   WORD_VALID out  WORD holds an unconsumed word
//   BUSY       out  a frame is in progress
//   OVERRUN    out  sticky: a completed word was dropped (cleared by reset)
//   PAR_ERR    out  sticky: parity mismatch (cleared by reset or next START)
// ============================================================================
module serial_in_receiver #(
  parameter logic [3:0] INIT_WORD  = 4'b0000,
  parameter bit         PARITY_ODD = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENB,
  input  logic [1:0] MODO,
  input  logic       DIR,
  input  logic       S_IN,
  input  logic       START,
  input  logic       WORD_ACK,
  output logic [3:0] WORD,
  output logic       WORD_VALID,
  output logic       BUSY,
  output logic       OVERRUN,
  output logic       PAR_ERR
);

`ifdef PARITY_CHK_EN
  typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

  state_t     state;
  logic [3:0] sr;         // shift register holding the frame under assembly
  logic [1:0] cnt;        // data bits already received in this frame
  logic [3:0] sr_shift;   // sr after taking the current S_IN bit
  logic       serial_mode;
  logic       word_done;  // a word completes on this edge
  logic [3:0] done_word;  // the word that completes on this edge

`ifdef PARITY_CHK_EN
  logic par_err;
  logic parity_ok;
`endif

  assign serial_mode = (MODO == 2'b00);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sr_shift  = DIR ? {S_IN, sr[3:1]} : {sr[2:0], S_IN};
    word_done = 1'b0;
    done_word = sr_shift;
`ifdef PARITY_CHK_EN
    // The data word plus its parity bit must XOR to the selected polarity.
    parity_ok = (((^sr) ^ S_IN) == PARITY_ODD);
    if (serial_mode && ENB && (state == PAR) && parity_ok) begin
      word_done = 1'b1;
      done_word = sr;
    end
`else
    if (serial_mode && ENB && (state == RECV) && (cnt == 2'd3)) begin
      word_done = 1'b1;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      sr         <= 4'b0000;
      cnt        <= 2'd0;
      WORD       <= INIT_WORD;
      WORD_VALID <= 1'b0;
      OVERRUN    <= 1'b0;
`ifdef PARITY_CHK_EN
      par_err    <= 1'b0;
`endif
    end else begin
      // Output handshake. A word completing on the same edge as an ACK
      // replaces the consumed word, so it is not an overrun.
      if (word_done) begin
        if (!WORD_VALID || WORD_ACK) begin
          WORD       <= done_word;
          WORD_VALID <= 1'b1;
        end else begin
          OVERRUN    <= 1'b1;
        end
      end else if (WORD_ACK) begin
        WORD_VALID <= 1'b0;
      end

      // Frame sequencing.
      if (state == IDLE) begin
        if (START && serial_mode) begin
          state   <= RECV;
          sr      <= 4'b0000;
          cnt     <= 2'd0;
`ifdef PARITY_CHK_EN
          par_err <= 1'b0;
`endif
        end
      end else if (!serial_mode) begin
        // Leaving serial mode abandons the frame; WORD is left untouched.
        state <= IDLE;
        sr    <= 4'b0000;
        cnt   <= 2'd0;
      end else if (ENB) begin
`ifdef PARITY_CHK_EN
        if (state == PAR) begin
          state <= IDLE;
          if (!parity_ok) par_err <= 1'b1;
        end else begin
          sr  <= sr_shift;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= PAR;
        end
`else
        sr  <= sr_shift;
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) state <= IDLE;
`endif
      end
    end
  end

  // State is a register, so BUSY is a direct decode of flop outputs.
  assign BUSY = (state != IDLE);

`ifdef PARITY_CHK_EN
  assign PAR_ERR = par_err;
`else
  assign PAR_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_serial_in_receiver.sv
// ============================================================================
// tb_serial_in_receiver
//
// Drives serial_in_receiver with directed frames followed by random traffic
// and compares every output each cycle against a frame-level reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge
// after the rising edge that consumed the inputs.
// ============================================================================
module tb_serial_in_receiver;

  localparam logic [3:0] TB_INIT = 4'b1010;
  localparam bit         TB_PODD = 1'b0;

  logic       CLK = 1'b0;
  logic       RESET, ENB, DIR, S_IN, START, WORD_ACK;
  logic [1:0] MODO;
  logic [3:0] WORD;
  logic       WORD_VALID, BUSY, OVERRUN, PAR_ERR;

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed per frame rather than per register.
  int   m_acc;      // word value assembled so far
  int   m_nbits;    // data bits received in the open frame
  bit   m_in_frame;
  bit   m_wait_par; // all data bits in, parity bit pending
  int   m_word;
  bit   m_valid, m_overrun, m_parerr;

  serial_in_receiver #(.INIT_WORD(TB_INIT), .PARITY_ODD(TB_PODD)) dut (
    .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODO(MODO), .DIR(DIR), .S_IN(S_IN),
    .START(START), .WORD_ACK(WORD_ACK), .WORD(WORD), .WORD_VALID(WORD_VALID),
    .BUSY(BUSY), .OVERRUN(OVERRUN), .PAR_ERR(PAR_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Applies the rules to one rising edge using the inputs the bench drove.
  task automatic model_update();
    bit complete = 1'b0;
    if (RESET) begin
      m_acc = 0; m_nbits = 0; m_in_frame = 0; m_wait_par = 0;
      m_word = TB_INIT; m_valid = 0; m_overrun = 0; m_parerr = 0;
      return;
    end
    if (!m_in_frame) begin
      if (START && MODO == 2'b00) begin
        m_in_frame = 1; m_nbits = 0; m_acc = 0; m_parerr = 0;
      end
    end else if (MODO != 2'b00) begin
      m_in_frame = 0; m_wait_par = 0; m_nbits = 0; m_acc = 0;
    end else if (ENB) begin
      if (m_wait_par) begin
        m_in_frame = 0; m_wait_par = 0;
        if ((($countones(m_acc) + int'(S_IN)) % 2) == int'(TB_PODD)) complete = 1;
        else m_parerr = 1;
      end else begin
        // Left: new bit is least significant; right: new bit is worth 8.
        if (DIR) m_acc = m_acc / 2 + int'(S_IN) * 8;
        else     m_acc = (m_acc * 2 + int'(S_IN)) % 16;
        m_nbits++;
        if (m_nbits == 4) begin
`ifdef PARITY_CHK_EN
          m_wait_par = 1;
`else
          complete = 1; m_in_frame = 0;
`endif
        end
      end
    end
    if (complete) begin
      if (m_valid && !WORD_ACK) m_overrun = 1;
      else begin m_word = m_acc; m_valid = 1; end
    end else if (WORD_ACK) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    check("word",    WORD,       m_word[3:0]);
    check("valid",   WORD_VALID, m_valid);
    check("busy",    BUSY,       m_in_frame);
    check("overrun", OVERRUN,    m_overrun);
    check("par_err", PAR_ERR,    m_parerr);
  endtask

  // One clock: drive inputs, let the edge happen, check against the model.
  task automatic cycle(input logic rst, input logic start, input logic enb,
                       input logic dir, input logic sin, input logic ack,
                       input logic [1:0] modo);
    RESET = rst; START = start; ENB = enb; DIR = dir; S_IN = sin;
    WORD_ACK = ack; MODO = modo;
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    compare_all();
  endtask

  // b[3] is sent first. ack_last raises WORD_ACK on the final bit of the frame.
  task automatic send_frame(input logic [3:0] b, input logic dir, input logic ack_last);
    cycle(0, 1, 0, 0, 0, 0, 2'b00);
    for (int i = 3; i >= 0; i--) begin
`ifdef PARITY_CHK_EN
      cycle(0, 0, 1, dir, b[i], 0, 2'b00);
`else
      cycle(0, 0, 1, dir, b[i], (i == 0) && ack_last, 2'b00);
`endif
    end
`ifdef PARITY_CHK_EN
    cycle(0, 0, 1, dir, (^b) ^ TB_PODD, ack_last, 2'b00);
`endif
  endtask

  initial begin
    RESET = 1; START = 0; ENB = 0; DIR = 0; S_IN = 0; WORD_ACK = 0; MODO = 2'b00;
    @(negedge CLK);
    cycle(1, 0, 0, 0, 0, 0, 2'b00);
    cycle(1, 1, 1, 0, 1, 1, 2'b00);
    check("rst_word",  WORD, TB_INIT);
    check("rst_valid", WORD_VALID, 0);
    check("rst_busy",  BUSY, 0);
    check("rst_ovr",   OVERRUN, 0);
    check("rst_perr",  PAR_ERR, 0);

    // Left shift, bits 1,0,1,1.
    cycle(0, 1, 0, 0, 0, 0, 2'b00);
    check("busy_after_start", BUSY, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, (i != 1), 0, 2'b00);
`ifndef PARITY_CHK_EN
    check("w1011", WORD, 4'b1011);
    check("w1011_valid", WORD_VALID, 1);
    check("w1011_busy", BUSY, 0);
`endif
    cycle(0, 0, 0, 0, 0, 1, 2'b00);

    // Right shift, bits 1,0,0,0, then acknowledge.
    send_frame(4'b1000, 1, 0);
    check("w0001", WORD, 4'b0001);
    check("w0001_valid", WORD_VALID, 1);
    cycle(0, 0, 0, 0, 0, 1, 2'b00);
    check("ack_clears", WORD_VALID, 0);

    // Two frames with no ACK: second is dropped.
    send_frame(4'b0110, 0, 0);
    send_frame(4'b1100, 0, 0);
    check("ovr_word_kept", WORD, 4'b0110);
    check("ovr_set", OVERRUN, 1);
    // Last bit coincides with ACK: replaces the word, no further overrun effect.
    send_frame(4'b0011, 0, 1);
    check("ack_same_edge_word", WORD, 4'b0011);
    check("ack_same_edge_valid", WORD_VALID, 1);
    check("ovr_sticky", OVERRUN, 1);

    // Abort by mode change after two bits.
    cycle(0, 1, 0, 0, 0, 0, 2'b00);
    cycle(0, 0, 1, 0, 1, 0, 2'b00);
    cycle(0, 0, 1, 0, 1, 0, 2'b00);
    cycle(0, 0, 0, 0, 0, 0, 2'b01);
    check("abort_busy", BUSY, 0);
    check("abort_word", WORD, 4'b0011);
    check("abort_valid", WORD_VALID, 1);
    // START outside serial mode is ignored.
    cycle(0, 1, 0, 0, 0, 0, 2'b10);
    check("start_ignored", BUSY, 0);

    // Reset mid-frame.
    cycle(0, 1, 0, 0, 0, 0, 2'b00);
    cycle(0, 0, 1, 1, 1, 0, 2'b00);
    cycle(0, 0, 1, 1, 0, 0, 2'b00);
    cycle(1, 0, 1, 1, 1, 0, 2'b00);
    check("midrst_word", WORD, TB_INIT);
    check("midrst_valid", WORD_VALID, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_ovr", OVERRUN, 0);

`ifdef PARITY_CHK_EN
    // Data 1,1,0,1 with a good then a bad parity bit.
    cycle(0, 1, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, (i != 2), 0, 2'b00);
    cycle(0, 0, 1, 0, 1, 0, 2'b00);
    check("par_good_valid", WORD_VALID, 1);
    check("par_good_word", WORD, 4'b1101);
    cycle(0, 1, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, (i != 2), 0, 2'b00);
    cycle(0, 0, 1, 0, 0, 0, 2'b00);
    check("par_bad_err", PAR_ERR, 1);
    check("par_bad_valid", WORD_VALID, 1);
    check("par_bad_ovr", OVERRUN, 0);
`endif

    // Random traffic, every output checked against the model each cycle.
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_in_receiver.md
SERIAL_IN_RECEIVER -- requirements
Module: serial_in_receiver

Interface
REQ-001 SHALL have parameter INIT_WORD, default 4'b0000: value driven on WORD while reset is asserted and after reset.
REQ-002 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; used only when PARITY_CHK_EN is defined.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ENB, input, 1 bit: bit strobe; S_IN is sampled only on edges where ENB=1.
REQ-007 SHALL have port MODO, input, 2 bits: operating mode; 2'b00 = serial shift mode, any other value = not shifting.
REQ-008 SHALL have port DIR, input, 1 bit: shift direction. 0 = left (bit enters bit 0); 1 = right (bit enters bit 3).
REQ-009 SHALL have port S_IN, input, 1 bit: serial data in.
REQ-010 SHALL have port START, input, 1 bit: frame start request.
REQ-011 SHALL have port WORD_ACK, input, 1 bit: consumer accepts WORD.
REQ-012 SHALL have port WORD, output, 4 bits: last completed word.
REQ-013 SHALL have port WORD_VALID, output, 1 bit: WORD holds an unconsumed word.
REQ-014 SHALL have port BUSY, output, 1 bit: a frame is in progress.
REQ-015 SHALL have port OVERRUN, output, 1 bit: sticky flag; a completed word was dropped.
REQ-016 SHALL have port PAR_ERR, output, 1 bit: sticky flag; parity mismatch.

Function
REQ-017 SHALL implement the FSM states IDLE and RECV, plus PAR when PARITY_CHK_EN is defined. BUSY=1 exactly when the FSM is outside IDLE.
REQ-018 In IDLE, START=1 with MODO=00 SHALL go to RECV on the next edge, clear the bit count and shift register SR, and clear PAR_ERR.
REQ-019 START SHALL be ignored outside IDLE, and in IDLE when MODO!=00.
REQ-020 In RECV, each edge with ENB=1 SHALL shift SR and increment the count (0..3):
- DIR=0: SR <= {SR[2:0], S_IN}
- DIR=1: SR <= {S_IN, SR[3:1]}
- DIR is sampled per bit.
REQ-021 In RECV or PAR, an edge with ENB=0 SHALL hold all state.
REQ-022 Without PARITY_CHK_EN, the edge sampling the 4th bit SHALL do all of the following:
- load WORD with the final SR value;
- set WORD_VALID, so it is visible in the following cycle (1-cycle latency);
- return the FSM to IDLE.
REQ-023 WORD_VALID SHALL clear on an edge with WORD_ACK=1 unless a new word completes on that same edge. In that case WORD loads the new word, WORD_VALID stays 1, and OVERRUN is unchanged.
REQ-024 If a word completes while WORD_VALID=1 and WORD_ACK=0, the new word SHALL be dropped, WORD SHALL keep its old value, and OVERRUN SHALL set.
REQ-025 WORD_ACK SHALL have no effect when WORD_VALID=0.
REQ-026 MODO!=00 on any edge in RECV or PAR SHALL abort the frame:
- FSM to IDLE;
- SR and count cleared;
- WORD and WORD_VALID unchanged.
REQ-027 OVERRUN SHALL clear only on reset.

Reset
REQ-028 RESET=1 on a rising edge SHALL take priority over all other inputs, including mid-frame, and SHALL produce: FSM=IDLE, SR=0, count=0, WORD=INIT_WORD, WORD_VALID=0, BUSY=0, OVERRUN=0, PAR_ERR=0.
REQ-029 Reset SHALL take effect only on a clock edge; there is no asynchronous path.

Configuration
REQ-030 With macro PARITY_CHK_EN defined:
- the 4th data bit SHALL move the FSM to PAR instead of completing the word;
- the next ENB=1 edge SHALL sample the parity bit on S_IN;
- the check passes when XOR(SR, parity) equals PARITY_ODD; on pass, the word completes per REQ-022 to REQ-024;
- on mismatch, the word SHALL be dropped and PAR_ERR SHALL set; the FSM returns to IDLE in both cases.
REQ-031 Without PARITY_CHK_EN: no PAR state, frames are 4 bits, and PAR_ERR SHALL be tied to 0.

Verification
REQ-032 Reset, then START with MODO=00, DIR=0 and S_IN bits 1,0,1,1 on four ENB edges -> WORD=4'b1011, WORD_VALID=1 one cycle after the 4th bit, BUSY=0.
REQ-033 DIR=1 with bits 1,0,0,0 -> WORD=4'b0001; then WORD_ACK=1 for one cycle -> WORD_VALID=0.
REQ-034 Complete two frames with no WORD_ACK -> WORD keeps the first value and OVERRUN=1. Then complete a frame whose last bit coincides with WORD_ACK -> new WORD, WORD_VALID=1.
REQ-035 Mid-frame (after 2 bits), apply MODO=01 -> BUSY=0 next cycle and WORD unchanged. Separately, RESET mid-frame -> all outputs at reset values and WORD=INIT_WORD.
REQ-036 With PARITY_CHK_EN and PARITY_ODD=0, send data 1,1,0,1 then parity 1 -> WORD_VALID=1. Send data 1,1,0,1 then parity 0 -> PAR_ERR=1, WORD_VALID unchanged.
